// File: rtl/iq_capture_pkg.sv
// Shared definitions for the IQ capture block: default widths and the
// capture FSM state encoding.
package iq_capture_pkg;

  localparam int DW_DEFAULT = 16;
  localparam int AW_DEFAULT = 10;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_ARMED   = 2'd1,
    ST_CAPTURE = 2'd2,
    ST_DONE    = 2'd3
  } state_e;

endpackage

// File: rtl/iq_capture_ram.sv
// Simple dual-port sample buffer: one write port and one read port with
// one cycle of read latency, shaped so synthesis maps it onto block RAM.
module iq_capture_ram
  import iq_capture_pkg::*;
#(
  parameter int DW = DW_DEFAULT,
  parameter int AW = AW_DEFAULT
) (
  input  logic            clk_i,
  input  logic            we_i,
  input  logic [AW-1:0]   waddr_i,
  input  logic [2*DW-1:0] wdata_i,
  input  logic [AW-1:0]   raddr_i,
  output logic [2*DW-1:0] rdata_o
);

  logic [2*DW-1:0] mem_q [2**AW];
  logic [2*DW-1:0] rdata_q;

  // No reset here: buffer contents and the read register survive rst.
  always_ff @(posedge clk_i) begin
    if (we_i) mem_q[waddr_i] <= wdata_i;
    rdata_q <= mem_q[raddr_i];
  end

  assign rdata_o = rdata_q;

endmodule

// File: rtl/iq_capture.sv
// IQ sample capture: arm, wait for an immediate or external-edge trigger,
// then store every (decim+1)-th valid sample until the latched length is met.
module iq_capture
  import iq_capture_pkg::*;
#(
  parameter int DW = DW_DEFAULT,
  parameter int AW = AW_DEFAULT
) (
  input  logic                 sys_clk,
  input  logic                 rst,
  input  logic                 in_valid,
  input  logic signed [DW-1:0] in_x,
  input  logic signed [DW-1:0] in_y,
  input  logic                 arm,
  input  logic                 abort,
  input  logic                 trig_ext,
  input  logic                 trig_mode,
  input  logic [AW:0]          num_samples,
  input  logic [7:0]           decim,
  input  logic [AW-1:0]        rd_addr,
  output logic [2*DW-1:0]      rd_data,
  output logic                 busy,
  output logic                 done,
  output logic [AW:0]          count
);

  localparam logic [AW:0] DEPTH = {1'b1, {AW{1'b0}}};

  state_e      state_q, state_d;
  logic [AW:0] count_q, count_d, len_q, len_d, countInc;
  logic [7:0]  decim_q, decim_d, decCnt_q, decCnt_d;
  logic        done_q, done_d, trigPrev_q;
  logic        trigRise, armAccept, takeSample, wrEn, lastWrite;

  assign trigRise   = trig_ext & ~trigPrev_q;
  assign armAccept  = arm && !abort && (state_q == ST_IDLE || state_q == ST_DONE);
  assign takeSample = (state_q == ST_CAPTURE) && in_valid && !abort;
  assign wrEn       = takeSample && (decCnt_q == 8'd0) && !rst;
  assign countInc   = count_q + 1'b1;
  assign lastWrite  = wrEn && (countInc == len_q);

  always_ff @(posedge sys_clk) begin
    if (rst) state_q <= ST_IDLE;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE, ST_DONE: if (armAccept) state_d = ST_ARMED;
      ST_ARMED: begin
        if (abort)                      state_d = ST_IDLE;
        else if (!trig_mode || trigRise) state_d = ST_CAPTURE;
      end
      ST_CAPTURE: begin
        if (abort)          state_d = ST_IDLE;
        else if (lastWrite) state_d = ST_DONE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    busy = (state_q == ST_ARMED) || (state_q == ST_CAPTURE);
  end

  // A length of zero is stored as DEPTH so the terminal compare needs no special case.
  always_comb begin
    count_d  = count_q;
    done_d   = done_q;
    decCnt_d = decCnt_q;
    len_d    = len_q;
    decim_d  = decim_q;
    if (armAccept) begin
      count_d  = '0;
      done_d   = 1'b0;
      decCnt_d = 8'd0;
      len_d    = (num_samples == '0) ? DEPTH : num_samples;
      decim_d  = decim;
    end else if (takeSample) begin
      if (decCnt_q == 8'd0) begin
        count_d  = countInc;
        decCnt_d = decim_q;
        if (countInc == len_q) done_d = 1'b1;
      end else begin
        decCnt_d = decCnt_q - 8'd1;
      end
    end
  end

  always_ff @(posedge sys_clk) begin
    if (rst) begin
      count_q    <= '0;
      done_q     <= 1'b0;
      decCnt_q   <= 8'd0;
      len_q      <= '0;
      decim_q    <= 8'd0;
      trigPrev_q <= 1'b0;
    end else begin
      count_q    <= count_d;
      done_q     <= done_d;
      decCnt_q   <= decCnt_d;
      len_q      <= len_d;
      decim_q    <= decim_d;
      trigPrev_q <= trig_ext;
    end
  end

  assign done  = done_q;
  assign count = count_q;

  iq_capture_ram #(
    .DW(DW),
    .AW(AW)
  ) u_ram (
    .clk_i   (sys_clk),
    .we_i    (wrEn),
    .waddr_i (count_q[AW-1:0]),
    .wdata_i ({in_x, in_y}),
    .raddr_i (rd_addr),
    .rdata_o (rd_data)
  );

endmodule

// File: tb/tb_iq_capture.sv
// Randomised bench for iq_capture: a list-based capture model fills a shadow
// buffer, and a forked monitor checks status and readback against queues.
module tb_iq_capture;

  localparam int DW    = 16;
  localparam int AW    = 10;
  localparam int DEPTH = 1 << AW;

  typedef struct packed {
    logic        busy;
    logic        done;
    logic [AW:0] count;
  } status_t;

  logic                 sys_clk;
  logic                 rst;
  logic                 in_valid;
  logic signed [DW-1:0] in_x, in_y;
  logic                 arm, abort, trig_ext, trig_mode;
  logic [AW:0]          num_samples;
  logic [7:0]           decim;
  logic [AW-1:0]        rd_addr;
  logic [2*DW-1:0]      rd_data;
  logic                 busy, done;
  logic [AW:0]          count;

  int checks = 0;
  int errors = 0;

  logic [2*DW-1:0] rdExpQ[$];
  status_t         statExpQ[$];
  logic            rdReq, statReq;
  logic [2*DW-1:0] mdlMem [DEPTH];
  int              lastAddrs[$];

  iq_capture #(.DW(DW), .AW(AW)) dut (
    .sys_clk     (sys_clk),
    .rst         (rst),
    .in_valid    (in_valid),
    .in_x        (in_x),
    .in_y        (in_y),
    .arm         (arm),
    .abort       (abort),
    .trig_ext    (trig_ext),
    .trig_mode   (trig_mode),
    .num_samples (num_samples),
    .decim       (decim),
    .rd_addr     (rd_addr),
    .rd_data     (rd_data),
    .busy        (busy),
    .done        (done),
    .count       (count)
  );

  initial sys_clk = 1'b0;
  always #5 sys_clk = ~sys_clk;

  initial begin
    #500000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog expired");
  end

  // Reads answer on the negedge one cycle after they were requested.
  task automatic monitor();
    logic            rdPendL = 1'b0;
    logic [2*DW-1:0] expRd;
    status_t         expSt, actSt;
    forever begin
      @(negedge sys_clk);
      if (rdPendL) begin
        checks++;
        if (rdExpQ.size() == 0) begin
          errors++;
          $display("[TB] FAIL rd_data: got %h with no expected read pending", rd_data);
        end else begin
          expRd = rdExpQ.pop_front();
          if (rd_data !== expRd) begin
            errors++;
            $display("[TB] FAIL rd_data: got %h, expected %h", rd_data, expRd);
          end
        end
      end
      rdPendL = rdReq;
      if (statReq) begin
        checks++;
        actSt = '{busy: busy, done: done, count: count};
        if (statExpQ.size() == 0) begin
          errors++;
          $display("[TB] FAIL status: no expected status pending");
        end else begin
          expSt = statExpQ.pop_front();
          if (actSt !== expSt) begin
            errors++;
            $display("[TB] FAIL status: got busy=%0b done=%0b count=%0d, expected busy=%0b done=%0b count=%0d",
                     actSt.busy, actSt.done, actSt.count, expSt.busy, expSt.done, expSt.count);
          end
        end
      end
    end
  endtask

  task automatic tick();
    @(posedge sys_clk);
    #1;
    arm      = 1'b0;
    abort    = 1'b0;
    rst      = 1'b0;
    in_valid = 1'b0;
    rdReq    = 1'b0;
    statReq  = 1'b0;
  endtask

  task automatic expectStatus(input logic b, input logic d, input int c);
    statExpQ.push_back('{busy: b, done: d, count: (AW+1)'(c)});
    statReq = 1'b1;
  endtask

  task automatic readWord(input int addr);
    tick();
    rd_addr = AW'(addr);
    rdReq   = 1'b1;
    rdExpQ.push_back(mdlMem[addr]);
  endtask

  // Eligible samples are the valid ones from the first CAPTURE cycle on;
  // the k-th stored word is eligible sample k*(dec+1).
  task automatic capture(input bit tmode, input int len, input int dec, input int riseAt,
                         input int killAt, input int killKind, input int validPct,
                         input bit countData);
    int lenEff = (len == 0) ? DEPTH : len;
    int start  = tmode ? riseAt + 1 : 2;
    int elig   = 0;
    int stored = 0;
    lastAddrs.delete();
    for (int rel = 0; rel < 3000; rel++) begin
      tick();
      if (rel == 0) begin
        arm         = 1'b1;
        num_samples = (AW+1)'(len);
        decim       = 8'(dec);
        trig_mode   = tmode;
      end else if ($urandom_range(9) == 0) begin
        arm = 1'b1;
      end
      if (tmode) trig_ext = (rel < riseAt / 2) || (rel >= riseAt);
      else       trig_ext = 1'($urandom);
      if (killAt >= 0 && rel >= start && stored == killAt) begin
        if (killKind == 1) begin
          abort = 1'b1;
          arm   = 1'b1;
        end else begin
          rst = 1'b1;
        end
        tick();
        expectStatus(1'b0, 1'b0, (killKind == 1) ? stored : 0);
        return;
      end
      in_valid = ($urandom_range(99) < validPct);
      if (countData && rel >= start) begin
        in_x = DW'(elig);
        in_y = -in_x;
      end else begin
        in_x = DW'($urandom);
        in_y = DW'($urandom);
      end
      if (rel == 1 || (tmode && rel == riseAt)) expectStatus(1'b1, 1'b0, 0);
      if (rel >= start && in_valid) begin
        if (elig % (dec + 1) == 0) begin
          mdlMem[stored] = {in_x, in_y};
          lastAddrs.push_back(stored);
          stored++;
        end
        elig++;
      end
      if (stored == lenEff) begin
        tick();
        expectStatus(1'b0, 1'b1, lenEff);
        return;
      end
    end
    checks++;
    errors++;
    $display("[TB] FAIL capture timeout: stored %0d words, required %0d", stored, lenEff);
  endtask

  task automatic readBack();
    foreach (lastAddrs[i]) readWord(lastAddrs[i]);
    tick();
    tick();
  endtask

  initial begin
    rst = 1'b1; in_valid = 1'b0; in_x = '0; in_y = '0;
    arm = 1'b0; abort = 1'b0; trig_ext = 1'b0; trig_mode = 1'b0;
    num_samples = '0; decim = '0; rd_addr = '0;
    rdReq = 1'b0; statReq = 1'b0;
    fork
      monitor();
    join_none

    repeat (3) begin
      @(posedge sys_clk);
      #1;
      rst = 1'b1;
    end
    tick();
    expectStatus(1'b0, 1'b0, 0);

    // Short immediate capture of a ramp, then a decimated one.
    capture(1'b0, 4, 0, 0, -1, 0, 100, 1'b1);
    readBack();
    capture(1'b0, 3, 2, 0, -1, 0, 100, 1'b1);
    readBack();

    // External trigger: level already high at arm, then low, rising at cycle 20.
    tick();
    trig_ext = 1'b1;
    tick();
    trig_ext = 1'b1;
    capture(1'b1, 8, 0, 20, -1, 0, 100, 1'b1);
    readBack();

    // Abort (with a coincident arm) after five writes, then random captures.
    capture(1'b0, 20, 0, 0, 5, 1, 70, 1'b0);
    readBack();
    for (int n = 0; n < 4; n++) begin
      capture(1'($urandom), $urandom_range(40, 1), $urandom_range(3), $urandom_range(15, 4),
              -1, 0, $urandom_range(100, 30), 1'b0);
      readBack();
    end

    // Reset in the middle of a capture keeps already written words.
    capture(1'b0, 20, 1, 0, 5, 2, 80, 1'b0);
    readWord(2);
    tick();
    tick();

    // Full-depth capture selected by a zero length.
    capture(1'b0, 0, 0, 0, -1, 0, 100, 1'b0);
    readBack();

    tick();
    tick();
    checks++;
    if (rdExpQ.size() != 0 || statExpQ.size() != 0) begin
      errors++;
      $display("[TB] FAIL drain: %0d reads and %0d status checks left, expected 0 and 0",
               rdExpQ.size(), statExpQ.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
